// File: rtl/cc_arb_pkg.sv
// Shared definitions for the crypto-cell APB arbiter: FSM states, bus widths,
// requester indices.
// Latency: n/a (declarations only). Backpressure: n/a.
package cc_arb_pkg;

    localparam int CC_ADDR_W = 12;
    localparam int CC_DATA_W = 32;

    // Requester indices: index 0 is the CPU bridge, index 1 the TRNG poller.
    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_POLL = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: picks a winner from req[1:0] using round-robin or fixed priority.
// Latency: purely combinational. Backpressure: none (winner is only meaningful when req != 0).
// Ports: req (requests), last_grant (previous owner), fixed_prio (1 = index 0 wins ties), winner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        unique case (req)
            2'b10:   winner = 1'b1;
            // Tie: fixed priority favours index 0, otherwise hand it to whoever did not go last.
            2'b11:   winner = fixed_prio ? 1'b0 : ~last_grant;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_apb_arbiter.sv
// Shares the crypto-cell APB slave port between the CPU bridge (m0) and TRNG poller (m1).
// Latency: req->ack 3+ACCESS_WAIT cycles; one transfer per 3+ACCESS_WAIT cycles back-to-back.
// Backpressure: requester holds req/command stable until its one-cycle ack; slave has no pready.
// Ports: m0_*/m1_* req/ack command interfaces, cc_* APB master, grant_id = current/last owner.
module cc_apb_arbiter
    import cc_arb_pkg::*;
#(
    parameter int unsigned ACCESS_WAIT = 0,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic                 m0_write,
    input  logic [CC_ADDR_W-1:0] m0_addr,
    input  logic [CC_DATA_W-1:0] m0_wdata,
    output logic                 m0_ack,
    output logic [CC_DATA_W-1:0] m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_write,
    input  logic [CC_ADDR_W-1:0] m1_addr,
    input  logic [CC_DATA_W-1:0] m1_wdata,
    output logic                 m1_ack,
    output logic [CC_DATA_W-1:0] m1_rdata,
    output logic                 cc_psel,
    output logic                 cc_penable,
    output logic                 cc_pwrite,
    output logic [CC_ADDR_W-1:0] cc_paddr,
    output logic [CC_DATA_W-1:0] cc_pwdata,
    input  logic [CC_DATA_W-1:0] cc_prdata,
    output logic                 grant_id
);

    localparam logic [3:0] WAIT_INIT = 4'(ACCESS_WAIT);

    state_e               state_q,  state_d;
    logic [3:0]           cnt_q,    cnt_d;
    logic                 psel_q,   psel_d;
    logic                 pen_q,    pen_d;
    logic                 pwrite_q, pwrite_d;
    logic [CC_ADDR_W-1:0] paddr_q,  paddr_d;
    logic [CC_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [1:0]           ack_q,    ack_d;
    logic [CC_DATA_W-1:0] rdata0_q, rdata0_d;
    logic [CC_DATA_W-1:0] rdata1_q, rdata1_d;
    logic                 grant_q,  grant_d;
    logic                 last_q,   last_d;

    logic [1:0]           req_eff;
    logic                 winner;

    // A requester being acked this cycle is still showing its old (or a fresh) command;
    // it must not win the bus again in the same cycle.
    assign req_eff = {m1_req & ~ack_q[1], m0_req & ~ack_q[0]};

    rr_arb2 u_arb (
        .req        (req_eff),
        .last_grant (last_q),
        .fixed_prio (FIXED_PRIO),
        .winner     (winner)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        psel_d   = psel_q;
        pen_d    = pen_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        ack_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant_d  = grant_q;
        last_d   = last_q;

        unique case (state_q)
            IDLE: begin
                if (|req_eff) begin
                    psel_d  = 1'b1;
                    grant_d = winner;
                    last_d  = winner;
                    if (winner == REQ_POLL) begin
                        pwrite_d = m1_write;
                        paddr_d  = m1_addr;
                        pwdata_d = m1_wdata;
                    end else begin
                        pwrite_d = m0_write;
                        paddr_d  = m0_addr;
                        pwdata_d = m0_wdata;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                pen_d   = 1'b1;
                cnt_d   = WAIT_INIT;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!pwrite_q) begin
                        if (grant_q == REQ_POLL) rdata1_d = cc_prdata;
                        else                     rdata0_d = cc_prdata;
                    end
                    ack_d[grant_q] = 1'b1;
                    // Drop the bus completely so the decoder never sees a stale address/data.
                    psel_d   = 1'b0;
                    pen_d    = 1'b0;
                    pwrite_d = 1'b0;
                    paddr_d  = '0;
                    pwdata_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            grant_q  <= REQ_CPU;
            last_q   <= REQ_POLL;   // so requester 0 wins the first tie
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    assign cc_psel    = psel_q;
    assign cc_penable = pen_q;
    assign cc_pwrite  = pwrite_q;
    assign cc_paddr   = paddr_q;
    assign cc_pwdata  = pwdata_q;
    assign m0_ack     = ack_q[0];
    assign m1_ack     = ack_q[1];
    assign m0_rdata   = rdata0_q;
    assign m1_rdata   = rdata1_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_cc_apb_arbiter.sv
// Testbench for cc_apb_arbiter: three instances (no wait/round-robin, 3 waits/round-robin,
// no wait/fixed priority) share the requester stimulus; one is observed at a time.
// Expected behaviour comes from a transfer-schedule model of the arbiter.
module tb_cc_apb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       req_v   = 2'b00;
    logic [1:0]       wr_v    = 2'b00;
    logic [1:0][11:0] addr_v  = '0;
    logic [1:0][31:0] wdata_v = '0;

    logic [2:0]       psel_w, pen_w, pwrite_w, ack0_w, ack1_w, gid_w;
    logic [2:0][11:0] paddr_w;
    logic [2:0][31:0] pwdata_w, prdata_w, rdata0_w, rdata1_w;

    logic [31:0] mem [1024];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign prdata_w[g] = mem[paddr_w[g][11:2]];
        cc_apb_arbiter #(
            .ACCESS_WAIT ((g == 1) ? 3 : 0),
            .FIXED_PRIO  (g == 2)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .m0_req     (req_v[0]),
            .m0_write   (wr_v[0]),
            .m0_addr    (addr_v[0]),
            .m0_wdata   (wdata_v[0]),
            .m0_ack     (ack0_w[g]),
            .m0_rdata   (rdata0_w[g]),
            .m1_req     (req_v[1]),
            .m1_write   (wr_v[1]),
            .m1_addr    (addr_v[1]),
            .m1_wdata   (wdata_v[1]),
            .m1_ack     (ack1_w[g]),
            .m1_rdata   (rdata1_w[g]),
            .cc_psel    (psel_w[g]),
            .cc_penable (pen_w[g]),
            .cc_pwrite  (pwrite_w[g]),
            .cc_paddr   (paddr_w[g]),
            .cc_pwdata  (pwdata_w[g]),
            .cc_prdata  (prdata_w[g]),
            .grant_id   (gid_w[g])
        );
    end

    // Observed instance
    logic [1:0]  sel = 2'd0;
    logic        o_psel, o_pen, o_pwrite, o_gid;
    logic [1:0]  o_ack;
    logic [11:0] o_paddr;
    logic [31:0] o_pwdata, o_rdata0, o_rdata1;

    always_comb begin
        o_psel   = psel_w[sel];
        o_pen    = pen_w[sel];
        o_pwrite = pwrite_w[sel];
        o_paddr  = paddr_w[sel];
        o_pwdata = pwdata_w[sel];
        o_ack    = {ack1_w[sel], ack0_w[sel]};
        o_rdata0 = rdata0_w[sel];
        o_rdata1 = rdata1_w[sel];
        o_gid    = gid_w[sel];
    end

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model (transfer schedule) ----------------
    int          cyc = 0;
    int          W   = 0;
    bit          FP  = 1'b0;
    bit          m_active;
    int          m_start;
    logic        m_win, m_last, m_gid, m_write;
    logic [11:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata [2];

    logic        exp_psel, exp_pen, exp_pwrite, exp_gid;
    logic [1:0]  exp_ack;
    logic [11:0] exp_paddr;
    logic [31:0] exp_pwdata;

    // Expected outputs for the current cycle, from the position inside the granted transfer:
    // rel 1 = SETUP, rel 2..2+W = ACCESS, rel 3+W = ack.
    task automatic model_eval();
        int rel;
        bit in_x;
        rel  = cyc - m_start;
        in_x = m_active && rel >= 1 && rel <= 2 + W;
        exp_psel   = in_x;
        exp_pen    = in_x && rel >= 2;
        exp_pwrite = in_x ? m_write : 1'b0;
        exp_paddr  = in_x ? m_addr  : 12'h000;
        exp_pwdata = in_x ? m_wdata : 32'h0;
        exp_ack    = 2'b00;
        if (m_active && rel == 3 + W) begin
            exp_ack[m_win] = 1'b1;
            if (!m_write) m_rdata[m_win] = mem[m_addr[11:2]];
        end
        exp_gid = m_gid;
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_start    = 0;
        m_last     = 1'b1;
        m_gid      = 1'b0;
        m_win      = 1'b0;
        m_write    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        model_eval();
    endtask

    // Bus free from the ack cycle on; a requester seeing its ack does not count this cycle.
    task automatic model_grant();
        logic [1:0] eff;
        logic       w;
        eff = req_v & ~exp_ack;
        if ((!m_active || (cyc - m_start) >= 3 + W) && eff != 2'b00) begin
            if (eff == 2'b11) w = FP ? 1'b0 : ~m_last;
            else              w = eff[1];
            m_last   = w;
            m_gid    = w;
            m_win    = w;
            m_start  = cyc;
            m_active = 1'b1;
            m_write  = wr_v[w];
            m_addr   = addr_v[w];
            m_wdata  = wdata_v[w];
        end
    endtask

    // ---------------- requesters ----------------
    int          issue_left [2];
    int          pct        [2];
    int          fix_addr   [2];   // -1 = random address
    int          wmode      [2];   // 0 read, 1 write, 2 random
    bit          use_fix_wd [2];
    logic [31:0] fix_wd     [2];
    int          issue_cyc  [2];

    task automatic issue(input int k);
        req_v[k]   = 1'b1;
        wr_v[k]    = (wmode[k] == 2) ? 1'($urandom_range(1)) : 1'(wmode[k]);
        addr_v[k]  = (fix_addr[k] >= 0) ? 12'(fix_addr[k]) : 12'($urandom_range(4095));
        wdata_v[k] = use_fix_wd[k] ? fix_wd[k] : $urandom;
        issue_left[k]--;
        issue_cyc[k] = cyc;
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if (req_v[k] && exp_ack[k]) req_v[k] = 1'b0;
            if (!req_v[k] && issue_left[k] > 0 && int'($urandom_range(99)) < pct[k]) issue(k);
        end
        model_grant();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        model_eval();
    endtask

    task automatic apply_reset(input logic [1:0] s);
        @(negedge clk);
        rst   = 1'b1;
        sel   = s;
        W     = (s == 2'd1) ? 3 : 0;
        FP    = (s == 2'd2);
        req_v = 2'b00;
        issue_left = '{0, 0};
        fix_addr   = '{-1, -1};
        wmode      = '{2, 2};
        pct        = '{100, 100};
        use_fix_wd = '{1'b0, 1'b0};
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            if ({psel_w[s], pen_w[s], pwrite_w[s], paddr_w[s], pwdata_w[s], ack0_w[s], ack1_w[s],
                 rdata0_w[s], rdata1_w[s], gid_w[s]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d psel=%b pen=%b paddr=%h pwdata=%h ack=%b%b rd0=%h rd1=%h gid=%b (all must be 0)",
                         s, psel_w[s], pen_w[s], paddr_w[s], pwdata_w[s], ack1_w[s], ack0_w[s],
                         rdata0_w[s], rdata1_w[s], gid_w[s]);
            end
            checks++;
        end
        apply_reset(2'd0);
        for (int i = 0; i < 3; i++) begin
            if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_ack, o_gid} !==
                {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata, exp_ack, exp_gid}) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc,
                         {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_ack, o_gid},
                         {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata, exp_ack, exp_gid});
            end
            checks++;
            step();
        end
    endtask

    task automatic test_single_read();
        int n_psel, n_pen, ack_cyc;
        bit pen_ok, m1_seen;
        logic [31:0] rd;
        n_psel = 0; n_pen = 0; ack_cyc = -1; pen_ok = 1'b1; m1_seen = 1'b0; rd = '0;
        apply_reset(2'd0);
        fix_addr = '{32'h104, -1};
        wmode    = '{0, 0};
        issue_left = '{1, 0};
        for (int i = 0; i < 8; i++) begin
            if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata} !== {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata}) begin
                failures++;
                $display("FAIL single_apb cyc=%0d got=%h exp=%h", cyc,
                         {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata}, {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata});
            end
            if ({o_ack, o_gid} !== {exp_ack, exp_gid}) begin
                failures++;
                $display("FAIL single_ack cyc=%0d got=%b exp=%b", cyc, {o_ack, o_gid}, {exp_ack, exp_gid});
            end
            checks += 2;
            if (o_psel) n_psel++;
            if (o_psel && o_pen) n_pen++;
            if (o_pen && (!o_psel || n_psel != 2)) pen_ok = 1'b0;
            if (o_ack[0]) begin ack_cyc = cyc; rd = o_rdata0; end
            if (o_ack[1]) m1_seen = 1'b1;
            step();
        end
        if (n_psel != 2 || n_pen != 1 || !pen_ok) begin
            failures++;
            $display("FAIL single_shape psel_cycles=%0d penable_cycles=%0d pen_in_2nd=%b required 2/1/1", n_psel, n_pen, pen_ok);
        end
        if (ack_cyc - issue_cyc[0] != 3) begin
            failures++;
            $display("FAIL single_latency got=%0d required=3", ack_cyc - issue_cyc[0]);
        end
        if (rd !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL single_rdata got=%h required=a5a50001", rd);
        end
        if (m1_seen) begin
            failures++;
            $display("FAIL single_m1_ack got=1 required=0");
        end
        checks += 4;
    endtask

    task automatic test_round_robin();
        int q_id[$];
        int q_cyc[$];
        apply_reset(2'd0);
        fix_addr   = '{32'h100, 32'h108};
        wmode      = '{0, 0};
        issue_left = '{4, 4};
        for (int i = 0; i < 30; i++) begin
            if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata} !== {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata}) begin
                failures++;
                $display("FAIL rr_apb cyc=%0d got=%h exp=%h", cyc,
                         {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata}, {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata});
            end
            if ({o_ack, o_gid} !== {exp_ack, exp_gid}) begin
                failures++;
                $display("FAIL rr_ack cyc=%0d got=%b exp=%b", cyc, {o_ack, o_gid}, {exp_ack, exp_gid});
            end
            if ({o_rdata1, o_rdata0} !== {m_rdata[1], m_rdata[0]}) begin
                failures++;
                $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", cyc, {o_rdata1, o_rdata0}, {m_rdata[1], m_rdata[0]});
            end
            checks += 3;
            if (|o_ack) begin q_id.push_back(int'(o_ack[1])); q_cyc.push_back(cyc); end
            step();
        end
        if (q_id.size() != 8) begin
            failures++;
            $display("FAIL rr_count got=%0d required=8", q_id.size());
        end
        checks++;
        for (int j = 0; j < q_id.size(); j++) begin
            if (q_id[j] != j % 2 || q_cyc[j] != 3 * (j + 1)) begin
                failures++;
                $display("FAIL rr_order idx=%0d got id=%0d cyc=%0d required id=%0d cyc=%0d", j, q_id[j], q_cyc[j], j % 2, 3 * (j + 1));
            end
            checks++;
        end
    endtask

    task automatic test_fixed_prio();
        int first, last_m0;
        apply_reset(2'd2);
        // Rounds where m0 went last: a tie from an idle bus must still go to m0.
        for (int r = 0; r < 4; r++) begin
            for (int ph = 0; ph < 2; ph++) begin
                issue_left = (ph == 0) ? '{1, 0} : '{1, 1};
                first = -1;
                for (int i = 0; i < 8; i++) begin
                    if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_ack, o_gid} !==
                        {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata, exp_ack, exp_gid}) begin
                        failures++;
                        $display("FAIL fp_bus cyc=%0d got=%h exp=%h", cyc,
                                 {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_ack, o_gid},
                                 {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata, exp_ack, exp_gid});
                    end
                    checks++;
                    if (first < 0 && |o_ack) first = int'(o_ack[1]);
                    step();
                end
                if (ph == 1) begin
                    if (first != 0) begin
                        failures++;
                        $display("FAIL fp_tie round=%0d first_acked=%0d required=0", r, first);
                    end
                    checks++;
                end
            end
        end
        // Continuous requests: m1 only gets in during m0's ack cycle.
        issue_left = '{5, 3};
        last_m0 = -100;
        for (int i = 0; i < 35; i++) begin
            if ({o_ack, o_gid, o_rdata1, o_rdata0} !== {exp_ack, exp_gid, m_rdata[1], m_rdata[0]}) begin
                failures++;
                $display("FAIL fp_cont cyc=%0d got=%h exp=%h", cyc,
                         {o_ack, o_gid, o_rdata1, o_rdata0}, {exp_ack, exp_gid, m_rdata[1], m_rdata[0]});
            end
            checks++;
            if (o_ack[0]) last_m0 = cyc;
            if (o_ack[1] && issue_left[0] > 0) begin
                if (cyc - last_m0 != 3) begin
                    failures++;
                    $display("FAIL fp_m1_slot cyc=%0d gap_from_m0_ack=%0d required=3", cyc, cyc - last_m0);
                end
                checks++;
            end
            step();
        end
    endtask

    task automatic test_wait_write();
        int n_pen, ack_cyc;
        bit stable_bad, post_bad, after;
        logic [31:0] prev_rd, rd;
        n_pen = 0; ack_cyc = -1; stable_bad = 1'b0; post_bad = 1'b0; after = 1'b0; rd = '0;
        apply_reset(2'd1);
        wmode = '{0, 0};
        issue_left = '{0, 1};
        for (int i = 0; i < 10; i++) begin
            if ({o_psel, o_pen, o_paddr, o_ack, o_rdata1} !== {exp_psel, exp_pen, exp_paddr, exp_ack, m_rdata[1]}) begin
                failures++;
                $display("FAIL ww_read cyc=%0d got=%h exp=%h", cyc,
                         {o_psel, o_pen, o_paddr, o_ack, o_rdata1}, {exp_psel, exp_pen, exp_paddr, exp_ack, m_rdata[1]});
            end
            checks++;
            step();
        end
        prev_rd = mem[addr_v[1][11:2]];
        fix_addr[1] = 32'h110; wmode[1] = 1; use_fix_wd[1] = 1'b1; fix_wd[1] = 32'hDEAD_BEEF;
        issue_left = '{0, 1};
        for (int i = 0; i < 12; i++) begin
            if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_ack, o_gid} !==
                {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata, exp_ack, exp_gid}) begin
                failures++;
                $display("FAIL ww_bus cyc=%0d got=%h exp=%h", cyc,
                         {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_ack, o_gid},
                         {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata, exp_ack, exp_gid});
            end
            checks++;
            if (o_pen) n_pen++;
            if (o_psel && (o_pwdata !== 32'hDEAD_BEEF || o_paddr !== 12'h110 || o_pwrite !== 1'b1)) stable_bad = 1'b1;
            if (o_ack[1]) begin ack_cyc = cyc; rd = o_rdata1; after = 1'b1; end
            if (after && (o_paddr !== 12'h0 || o_pwdata !== 32'h0 || o_psel !== 1'b0)) post_bad = 1'b1;
            step();
        end
        if (n_pen != 4) begin
            failures++;
            $display("FAIL ww_penable_cycles got=%0d required=4", n_pen);
        end
        if (stable_bad) begin
            failures++;
            $display("FAIL ww_stable got=unstable required=stable 110/deadbeef");
        end
        if (ack_cyc - issue_cyc[1] != 6) begin
            failures++;
            $display("FAIL ww_latency got=%0d required=6", ack_cyc - issue_cyc[1]);
        end
        if (rd !== prev_rd) begin
            failures++;
            $display("FAIL ww_rdata_kept got=%h required=%h", rd, prev_rd);
        end
        if (post_bad) begin
            failures++;
            $display("FAIL ww_bus_cleared got=nonzero required=0");
        end
        checks += 5;
    endtask

    task automatic test_reset_mid();
        int first;
        apply_reset(2'd0);
        wmode = '{0, 0};
        issue_left = '{1, 0};
        step();
        step();
        if ({o_psel, o_pen} !== 2'b11) begin
            failures++;
            $display("FAIL rm_in_access got=%b required=11", {o_psel, o_pen});
        end
        rst = 1'b1;
        #1;
        if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_ack, o_rdata0, o_rdata1, o_gid} !== '0) begin
            failures++;
            $display("FAIL rm_async_clear got=%h required=0",
                     {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_ack, o_rdata0, o_rdata1, o_gid});
        end
        req_v = 2'b00;
        issue_left = '{0, 0};
        @(posedge clk);
        @(negedge clk);
        if ({o_ack, o_psel, o_rdata0} !== '0) begin
            failures++;
            $display("FAIL rm_no_ack got=%h required=0", {o_ack, o_psel, o_rdata0});
        end
        checks += 3;
        rst = 1'b0;
        cyc = 0;
        model_reset();
        issue_left = '{1, 1};
        first = -1;
        for (int i = 0; i < 8; i++) begin
            if ({o_psel, o_pen, o_paddr, o_ack, o_gid, o_rdata0, o_rdata1} !==
                {exp_psel, exp_pen, exp_paddr, exp_ack, exp_gid, m_rdata[0], m_rdata[1]}) begin
                failures++;
                $display("FAIL rm_after cyc=%0d got=%h exp=%h", cyc,
                         {o_psel, o_pen, o_paddr, o_ack, o_gid, o_rdata0, o_rdata1},
                         {exp_psel, exp_pen, exp_paddr, exp_ack, exp_gid, m_rdata[0], m_rdata[1]});
            end
            checks++;
            if (first < 0 && |o_ack) first = int'(o_ack[1]);
            step();
        end
        if (first != 0) begin
            failures++;
            $display("FAIL rm_first_after_reset got=%0d required=0", first);
        end
        checks++;
    endtask

    task automatic test_withdraw();
        int n_ack1;
        n_ack1 = 0;
        apply_reset(2'd0);
        wmode = '{0, 0};
        issue_left = '{0, 1};
        for (int i = 0; i < 10; i++) begin
            if ({o_psel, o_pen, o_paddr, o_ack, o_gid, o_rdata1} !==
                {exp_psel, exp_pen, exp_paddr, exp_ack, exp_gid, m_rdata[1]}) begin
                failures++;
                $display("FAIL wd_bus cyc=%0d got=%h exp=%h", cyc,
                         {o_psel, o_pen, o_paddr, o_ack, o_gid, o_rdata1},
                         {exp_psel, exp_pen, exp_paddr, exp_ack, exp_gid, m_rdata[1]});
            end
            checks++;
            if (o_ack[1]) n_ack1++;
            if (i == 1) req_v[1] = 1'b0;   // withdrawn during SETUP
            step();
        end
        if (n_ack1 != 1 || o_psel !== 1'b0) begin
            failures++;
            $display("FAIL wd_single_ack acks=%0d psel=%b required acks=1 psel=0", n_ack1, o_psel);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            apply_reset(2'(r % 3));
            pct        = '{int'($urandom_range(100, 10)), int'($urandom_range(100, 10))};
            issue_left = '{int'($urandom_range(20, 5)), int'($urandom_range(20, 5))};
            for (int i = 0; i < 200; i++) begin
                if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata} !== {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata}) begin
                    failures++;
                    $display("FAIL rnd_apb dut=%0d cyc=%0d got=%h exp=%h", sel, cyc,
                             {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata}, {exp_psel, exp_pen, exp_pwrite, exp_paddr, exp_pwdata});
                end
                if ({o_ack, o_gid} !== {exp_ack, exp_gid}) begin
                    failures++;
                    $display("FAIL rnd_ack dut=%0d cyc=%0d got=%b exp=%b", sel, cyc, {o_ack, o_gid}, {exp_ack, exp_gid});
                end
                if ({o_rdata1, o_rdata0} !== {m_rdata[1], m_rdata[0]}) begin
                    failures++;
                    $display("FAIL rnd_rdata dut=%0d cyc=%0d got=%h exp=%h", sel, cyc, {o_rdata1, o_rdata0}, {m_rdata[1], m_rdata[0]});
                end
                checks += 3;
                step();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[32'h104 >> 2] = 32'hA5A5_0001;
        issue_left = '{0, 0};
        pct        = '{100, 100};
        fix_addr   = '{-1, -1};
        wmode      = '{2, 2};
        use_fix_wd = '{1'b0, 1'b0};
        fix_wd     = '{32'h0, 32'h0};
        issue_cyc  = '{0, 0};
        model_reset();

        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_wait_write();
        test_reset_mid();
        test_withdraw();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
